// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - funct3 encodings for the supported load/store widths
//   - memory size codes driven on mem_byte
//   - FSM state type
//   - decode helpers (legality, size, alignment)
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return store;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return SZ_HALF;
            F3_W:        return SZ_WORD;
            default:     return SZ_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: request, response and data-memory signals of the load/store controller.
//   slave  : the controller view (accepts requests, drives responses and memory)
//   master : the core + memory view (issues requests, consumes responses,
//            returns combinational read data)
interface lsu_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_wr;
    logic [1:0]        mem_byte;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_byte, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_byte, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extension.
//   funct3 : load encoding (LB/LH/LW/LBU/LHU)
//   rdata  : raw memory read data, low-aligned
//   ext    : sign/zero-extended result; 0 for any other encoding
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        funct3,
    input  logic [DWIDTH-1:0] rdata,
    output logic [DWIDTH-1:0] ext
);
    always_comb begin
        ext = '0;
        case (funct3)
            F3_B:    ext = {{(DWIDTH-8){rdata[7]}}, rdata[7:0]};
            F3_H:    ext = {{(DWIDTH-16){rdata[15]}}, rdata[15:0]};
            F3_W:    ext = rdata;
            F3_BU:   ext = {{(DWIDTH-8){1'b0}}, rdata[7:0]};
            F3_HU:   ext = {{(DWIDTH-16){1'b0}}, rdata[15:0]};
            default: ext = '0;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller (IDLE -> ACCESS -> RESP).
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsu_if.slave -- req_* handshake in, rsp_* handshake out,
//              mem_* data-memory port (combinational mem_rdata)
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses with rsp_err instead of passing them to memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    lsu_state_e        state_q, state_d;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] rdata_q;
    logic              rsp_err_q;
    logic [DWIDTH-1:0] ext_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign err_d = f3_illegal(bus.req_store, bus.req_funct3)
                 || misaligned(f3_size(bus.req_funct3), bus.req_addr[1:0]);
`else
    assign err_d = f3_illegal(bus.req_store, bus.req_funct3);
`endif

    lsu_load_ext #(.DWIDTH(DWIDTH)) u_ext (
        .funct3 (f3_q),
        .rdata  (bus.mem_rdata),
        .ext    (ext_data)
    );

    // The request registers double as the memory-side outputs: they only
    // change on a request handshake, so address/data hold between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            store_q   <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_BYTE;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                store_q <= bus.req_store;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= f3_size(bus.req_funct3);
                err_q   <= err_d;
            end
            if (state_q == ACCESS) begin
                rdata_q   <= (!store_q && !err_q) ? ext_data : '0;
                rsp_err_q <= err_q;
            end
        end
    end

    // mem_wr is deliberately not gated by rst: a store whose ACCESS cycle
    // meets the reset edge still commits, since memory samples it there.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                bus.mem_wr = store_q && !err_q;
                state_d    = RESP;
            end
            RESP: begin
                bus.rsp_valid = !rst;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_byte  = size_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a byte-addressed memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   rsp_cnt = 0;

    always #5 clk = ~clk;

    lsu_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    lsu_ctrl #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte-granular memory, little-endian, address wraps at 256 bytes.
    logic [7:0] mem [256];
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = bus.mem_addr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        bus.mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    end

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            mem[a0] <= bus.mem_wdata[7:0];
            if (bus.mem_byte != SZ_BYTE) mem[a1] <= bus.mem_wdata[15:8];
            if (bus.mem_byte == SZ_WORD) begin
                mem[a2] <= bus.mem_wdata[23:16];
                mem[a3] <= bus.mem_wdata[31:24];
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; starts and ends at a negedge in IDLE.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int wrs, output logic [1:0] sz);
        int wr0;
        wr0 = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        sz = bus.mem_byte;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        wrs = wr_cnt - wr0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wrs;
        logic [1:0]  sz;
        int          rc0;

        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst_mem_wr",    32'(bus.mem_wr),    32'd0);
        chk("rst_mem_byte",  32'(bus.mem_byte),  32'd0);
        chk("rst_mem_addr",  bus.mem_addr,       32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // SW then LW
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, wrs, sz);
        chk("sw_wr_pulses", 32'(wrs), 32'd1);
        chk("sw_size",      32'(sz),  32'd2);
        chk("sw_err",       32'(er),  32'd0);
        chk("sw_rdata",     rd,       32'd0);
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, wrs, sz);
        chk("lw_data",  rd,        32'hDEADBEEF);
        chk("lw_err",   32'(er),   32'd0);
        chk("lw_nowr",  32'(wrs),  32'd0);

        // Extension variants on 0x000080F0
        do_req(1'b1, F3_W, 32'h20, 32'h000080F0, rd, er, wrs, sz);
        do_req(1'b1, F3_W, 32'h24, 32'h11223344, rd, er, wrs, sz);
        do_req(1'b0, F3_B,  32'h20, 32'h0, rd, er, wrs, sz);
        chk("lb",  rd, 32'hFFFFFFF0);
        do_req(1'b0, F3_BU, 32'h20, 32'h0, rd, er, wrs, sz);
        chk("lbu", rd, 32'h000000F0);
        do_req(1'b0, F3_H,  32'h20, 32'h0, rd, er, wrs, sz);
        chk("lh",  rd, 32'hFFFF80F0);
        chk("lh_size", 32'(sz), 32'd1);
        do_req(1'b0, F3_HU, 32'h20, 32'h0, rd, er, wrs, sz);
        chk("lhu", rd, 32'h000080F0);

        // Illegal encodings
        do_req(1'b1, 3'b100, 32'h10, 32'h12345678, rd, er, wrs, sz);
        chk("st100_err",  32'(er),  32'd1);
        chk("st100_data", rd,       32'd0);
        chk("st100_nowr", 32'(wrs), 32'd0);
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, wrs, sz);
        chk("st100_mem_intact", rd, 32'hDEADBEEF);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, wrs, sz);
        chk("ld011_err",  32'(er), 32'd1);
        chk("ld011_data", rd,      32'd0);
        do_req(1'b1, 3'b111, 32'h10, 32'hFFFFFFFF, rd, er, wrs, sz);
        chk("st111_err",  32'(er),  32'd1);
        chk("st111_nowr", 32'(wrs), 32'd0);

        // Misaligned word load
        do_req(1'b0, F3_W, 32'h22, 32'h0, rd, er, wrs, sz);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw22_err",  32'(er), 32'd1);
        chk("lw22_data", rd,      32'd0);
`else
        chk("lw22_err",  32'(er), 32'd0);
        chk("lw22_data", rd,      32'h33440000);
`endif

        // Response back-pressure
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata,      32'hDEADBEEF);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_BU;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_next_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_data", bus.rsp_rdata, 32'h000000EF);
        @(posedge clk);
        @(negedge clk);

        // Reset during RESP
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rr_pre_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rr_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rr_mem_addr",  bus.mem_addr,       32'd0);
        chk("rr_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("rr_idle_ready", 32'(bus.req_ready), 32'd1);

        // Reset during ACCESS of an SB
        @(negedge clk);
        rc0 = rsp_cnt;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h5A5A5AA5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("ra_mem_wr", 32'(bus.mem_wr), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ra_mem_wr_clr", 32'(bus.mem_wr),   32'd0);
        chk("ra_mem_addr",   bus.mem_addr,      32'd0);
        chk("ra_mem_wdata",  bus.mem_wdata,     32'd0);
        chk("ra_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ra_no_rsp",  32'(rsp_cnt - rc0), 32'd0);
        chk("ra_mem_byte", 32'(mem[8'h30]),   32'h000000A5);
        do_req(1'b0, F3_BU, 32'h30, 32'h0, rd, er, wrs, sz);
        chk("ra_lbu", rd, 32'h000000A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
